// File: rtl/button_pkg.sv
// Shared definitions for the button path: debouncer FSM states and default sizing.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  localparam int STABLE_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int BOUNCE_CNT_W_DEF  = 8;

endpackage

// File: rtl/sync_ff.sv
// N-stage flop chain bringing an asynchronous level into the i_clk domain.
module sync_ff #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronizes a bouncy button and accepts a level only after STABLE_CYCLES steady samples.
// Optional bounce statistics counter: define BUTTON_DEBOUNCER_STATS_EN.
module button_debouncer
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int BOUNCE_CNT_W  = BOUNCE_CNT_W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_btn,
  output logic                    o_btn_level,
  output logic                    o_press,
  output logic                    o_release,
  output logic [BOUNCE_CNT_W-1:0] o_bounce_cnt
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_s;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  sync_ff #(.N(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn),
    .o_q     (w_s)
  );

  // A revert on the final count beats completion: the abort check comes first.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_s) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (!w_s) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!w_s) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (w_s) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= IDLE_LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_btn_level = r_level;
  assign o_press     = r_press;
  assign o_release   = r_release;

`ifdef BUTTON_DEBOUNCER_STATS_EN
  logic                    w_abort;
  logic [BOUNCE_CNT_W-1:0] r_bounce_cnt;

  assign w_abort = ((r_state == WAIT_HIGH) && !w_s) || ((r_state == WAIT_LOW) && w_s);

  // Saturating: a stuck-bouncy switch must not wrap back to a small count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                            r_bounce_cnt <= '0;
    else if (w_abort && (r_bounce_cnt != '1)) r_bounce_cnt <= r_bounce_cnt + 1'b1;
  end

  assign o_bounce_cnt = r_bounce_cnt;
`else
  assign o_bounce_cnt = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: latency, glitch/bounce rejection, reset, saturation.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       lvl, prs, rel;
  logic [7:0] bc;

  int n_chk = 0, n_fail = 0, n_press = 0, n_rel = 0;
  logic last_press = 1'b0;
  logic prev_strobe = 1'b0;

`ifdef BUTTON_DEBOUNCER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  button_debouncer #(.STABLE_CYCLES(16), .SYNC_STAGES(2), .BOUNCE_CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_btn        (btn),
    .o_btn_level  (lvl),
    .o_press      (prs),
    .o_release    (rel),
    .o_bounce_cnt (bc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] bexp(input int n);
    if (!STATS) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  // Caller has just made btn's new value visible to the next edge (edge k).
  task automatic edge_check(input logic v, input string tag);
    tick(17);
    chk({tag, "_pre_strobe"}, v ? prs : rel, 0);
    chk({tag, "_pre_level"}, lvl, !v);
    tick(1);
    chk({tag, "_strobe"}, v ? prs : rel, 1);
    chk({tag, "_level"}, lvl, v);
    tick(1);
    chk({tag, "_strobe_1cyc"}, v ? prs : rel, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_press  = 1'b0;
      prev_strobe = 1'b0;
    end else begin
      if (prs | rel) begin
        chk("strobe_excl", prs & rel, 0);
        chk("strobe_gap", prev_strobe, 0);
        if (prs) begin chk("press_alt", last_press, 0);  last_press = 1'b1; n_press++; end
        if (rel) begin chk("release_alt", !last_press, 0); last_press = 1'b0; n_rel++; end
      end
      prev_strobe = prs | rel;
    end
  end

  initial begin
    int np, nr;
    logic tgt;
    rst_n = 1'b0;
    btn   = 1'b1;
    tick(3);
    chk("rst_level", lvl, 0);
    chk("rst_press", prs, 0);
    chk("rst_release", rel, 0);
    chk("rst_bounce", bc, 0);

    // btn held high through reset release
    rst_n = 1'b1;
    edge_check(1'b1, "rst_rel");

    btn = 1'b0;
    edge_check(1'b0, "clean_rel");

    np = n_press;
    btn = 1'b1;
    edge_check(1'b1, "clean_press");
    tick(21);
    chk("clean_press_cnt", n_press - np, 1);
    chk("clean_press_hold", lvl, 1);
    chk("clean_press_bc", bc, 0);

    nr = n_rel;
    np = n_press;
    for (int i = 0; i < 4; i++) begin
      btn = 1'b0; tick(3);
      btn = 1'b1; tick(3);
    end
    chk("bouncy_hold", lvl, 1);
    btn = 1'b0;
    edge_check(1'b0, "bouncy_rel");
    chk("bouncy_rel_cnt", n_rel - nr, 1);
    chk("bouncy_press_cnt", n_press - np, 0);
    chk("bouncy_bc", bc, bexp(4));

    // 15 synchronized samples: reverts exactly at cnt==STABLE_CYCLES-1
    np = n_press;
    btn = 1'b1; tick(15);
    btn = 1'b0; tick(30);
    chk("glitch_level", lvl, 0);
    chk("glitch_press_cnt", n_press - np, 0);
    chk("glitch_bc", bc, bexp(5));

    // 16-cycle pulse is the shortest accepted
    btn = 1'b1; tick(16);
    btn = 1'b0; tick(1);
    chk("min_pre_press", prs, 0);
    tick(1);
    chk("min_press", prs, 1);
    chk("min_level", lvl, 1);
    tick(15);
    chk("min_pre_rel", rel, 0);
    tick(1);
    chk("min_rel", rel, 1);
    chk("min_rel_level", lvl, 0);
    chk("min_bc", bc, bexp(5));

    // reset while in WAIT_HIGH
    np = n_press;
    btn = 1'b1; tick(6);
    rst_n = 1'b0; btn = 1'b0; tick(1);
    chk("midrst_level", lvl, 0);
    chk("midrst_press", prs, 0);
    chk("midrst_bc", bc, 0);
    rst_n = 1'b1; tick(30);
    chk("midrst_after_level", lvl, 0);
    chk("midrst_press_cnt", n_press - np, 0);

    repeat (300) begin
      btn = 1'b1; tick(1);
      btn = 1'b0; tick(3);
    end
    chk("sat_bc", bc, bexp(300));
    chk("sat_level", lvl, 0);

    // bouncy presses/releases with bursts shorter than STABLE_CYCLES
    np = n_press;
    nr = n_rel;
    for (int i = 0; i < 20; i++) begin
      tgt = (i % 2 == 0);
      repeat ($urandom_range(1, 4)) begin
        btn = tgt;  tick($urandom_range(1, 5));
        btn = !tgt; tick($urandom_range(1, 5));
      end
      btn = tgt;
      tick(40);
      chk("soak_level", lvl, tgt);
    end
    chk("soak_press_cnt", n_press - np, 10);
    chk("soak_rel_cnt", n_rel - nr, 10);

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
